// File: rtl/gpia_pkg.sv
// Shared constants for the GPIA Wishbone port: output-byte modes, register map
// and the default synchronizer depth.
package gpia_pkg;

    localparam logic [1:0] GPIA_MODE_WRITE = 2'b00;
    localparam logic [1:0] GPIA_MODE_SET   = 2'b01;
    localparam logic [1:0] GPIA_MODE_CLR   = 2'b10;
    localparam logic [1:0] GPIA_MODE_TGL   = 2'b11;

    localparam logic [2:0] GPIA_A_OUT  = 3'd0;  // 0..3 alias the output byte, low bits pick the mode
    localparam logic [2:0] GPIA_A_IN   = 3'd4;
    localparam logic [2:0] GPIA_A_STAT = 3'd5;
    localparam logic [2:0] GPIA_A_MASK = 3'd6;
    localparam logic [2:0] GPIA_A_POL  = 3'd7;

    localparam int GPIA_SYNC_STAGES_DEF = 2;

    function automatic logic gpia_is_out(input logic [2:0] adr);
        return ~adr[2];
    endfunction

endpackage

// File: rtl/gpia_sync_edge.sv
// Input-pin synchronizer with a previous-sample register and polarity-selected
// edge detection; edges are suppressed until the chain has filled after reset.
module gpia_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_pins,
    input  logic [7:0] i_pol,
    output logic [7:0] o_sync,
    output logic [7:0] o_edge
);

    logic [SYNC_STAGES-1:0][7:0] r_sync;
    logic [7:0]                  r_prev;
    logic [2:0]                  r_cnt;
    logic                        r_armed;
    logic [7:0]                  w_s;
    logic [7:0]                  w_raw;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_prev  <= '0;
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pins};
            r_prev <= w_s;
            // Arm once prev holds a real sample, so pins high through reset never count.
            if (!r_armed) begin
                if (r_cnt == 3'(SYNC_STAGES)) r_armed <= 1'b1;
                else                          r_cnt   <= r_cnt + 3'd1;
            end
        end
    end

    assign w_raw  = (i_pol & w_s & ~r_prev) | (~i_pol & ~w_s & r_prev);
    assign o_edge = r_armed ? w_raw : 8'h00;
    assign o_sync = w_s;

endmodule

// File: rtl/gpia_wb_port.sv
// Wishbone classic slave for one GPIA output byte and one input byte with
// latched edge status and a maskable level interrupt.
module gpia_wb_port
    import gpia_pkg::*;
#(
    parameter int         SYNC_STAGES = GPIA_SYNC_STAGES_DEF,
    parameter logic [7:0] RESET_POL   = 8'hFF
) (
    input  logic       clk_i,
    input  logic       res_i,
    input  logic [2:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    input  logic       we_i,
    input  logic       cyc_i,
    input  logic       stb_i,
    output logic       ack_o,
    output logic [1:0] mode_o,
    output logic [7:0] d_o,
    output logic       gstb_o,
    input  logic [7:0] q_i,
    input  logic [7:0] port_i,
    output logic       irq_o
);

    logic [7:0] r_status;
    logic [7:0] r_mask;
    logic [7:0] r_pol;
    logic [7:0] w_sync;
    logic [7:0] w_edge;
    logic       w_req;
    logic       w_wr;
    logic [7:0] w_w1c;
    logic [7:0] w_rdata;

    gpia_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk  (clk_i),
        .i_rst  (res_i),
        .i_pins (port_i),
        .i_pol  (r_pol),
        .o_sync (w_sync),
        .o_edge (w_edge)
    );

    // Gating on ack_o gives exactly one wait state and every-other-cycle acks.
    assign w_req = cyc_i & stb_i & ~ack_o;
    assign w_wr  = w_req & we_i;
    assign w_w1c = (w_wr && adr_i == GPIA_A_STAT) ? dat_i : 8'h00;

    always_comb begin
        w_rdata = q_i;
        case (adr_i)
            GPIA_A_IN:   w_rdata = w_sync;
            GPIA_A_STAT: w_rdata = r_status;
            GPIA_A_MASK: w_rdata = r_mask;
            GPIA_A_POL:  w_rdata = r_pol;
            default:     w_rdata = q_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            ack_o    <= 1'b0;
            gstb_o   <= 1'b0;
            mode_o   <= GPIA_MODE_WRITE;
            d_o      <= 8'h00;
            dat_o    <= 8'h00;
            irq_o    <= 1'b0;
            r_status <= 8'h00;
            r_mask   <= 8'h00;
            r_pol    <= RESET_POL;
        end else begin
            ack_o  <= w_req;
            gstb_o <= w_wr & gpia_is_out(adr_i);
            dat_o  <= w_req ? w_rdata : 8'h00;
            if (w_wr && gpia_is_out(adr_i)) begin
                mode_o <= adr_i[1:0];
                d_o    <= dat_i;
            end
            if (w_wr && adr_i == GPIA_A_MASK) r_mask <= dat_i;
            if (w_wr && adr_i == GPIA_A_POL)  r_pol  <= dat_i;
            // A fresh edge overrides a simultaneous clear on the same bit.
            r_status <= (r_status & ~w_w1c) | w_edge;
            irq_o    <= |(r_status & r_mask);
        end
    end

endmodule

// File: tb/tb_gpia_wb_port.sv
// Directed bench for gpia_wb_port with a behavioural GPIA output byte on q_i.
module tb_gpia_wb_port;
    import gpia_pkg::*;

    logic       clk_i = 1'b0;
    logic       res_i = 1'b1;
    logic [2:0] adr_i = '0;
    logic [7:0] dat_i = '0;
    logic [7:0] dat_o;
    logic       we_i  = 1'b0;
    logic       cyc_i = 1'b0;
    logic       stb_i = 1'b0;
    logic       ack_o;
    logic [1:0] mode_o;
    logic [7:0] d_o;
    logic       gstb_o;
    logic [7:0] q_i;
    logic [7:0] port_i = 8'hFF;
    logic       irq_o;

    int n_vec  = 0;
    int n_miss = 0;

    logic       s_ack, s_gstb;
    logic [1:0] s_mode;
    logic [7:0] s_d, s_dat;
    logic       irq_seen;

    gpia_wb_port #(.SYNC_STAGES(2), .RESET_POL(8'hFF)) dut (
        .clk_i(clk_i), .res_i(res_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .we_i(we_i), .cyc_i(cyc_i), .stb_i(stb_i), .ack_o(ack_o),
        .mode_o(mode_o), .d_o(d_o), .gstb_o(gstb_o), .q_i(q_i),
        .port_i(port_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Output byte: applies the committed (mode, d) on the edge after gstb.
    always @(posedge clk_i or posedge res_i) begin
        if (res_i) q_i <= 8'h00;
        else if (gstb_o) begin
            case (mode_o)
                GPIA_MODE_WRITE: q_i <= d_o;
                GPIA_MODE_SET:   q_i <= q_i | d_o;
                GPIA_MODE_CLR:   q_i <= q_i & ~d_o;
                default:         q_i <= q_i ^ d_o;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // One transaction; cyc/stb drop right after the request edge, outputs captured in the ack cycle.
    task automatic wb_cycle(input logic we, input logic [2:0] a, input logic [7:0] d);
        @(posedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = a; dat_i = d;
        @(posedge clk_i); #1;
        s_ack = ack_o; s_gstb = gstb_o; s_mode = mode_o; s_d = d_o; s_dat = dat_o;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    initial begin
        // 1: reset with pins high, nothing latches
        repeat (3) @(posedge clk_i);
        #1 res_i = 1'b0;
        chk("rst_ack",  8'(ack_o),  8'h00);
        chk("rst_gstb", 8'(gstb_o), 8'h00);
        chk("rst_mode", 8'(mode_o), 8'h00);
        chk("rst_d",    d_o,        8'h00);
        chk("rst_dat",  dat_o,      8'h00);
        chk("rst_irq",  8'(irq_o),  8'h00);
        wb_cycle(1'b1, GPIA_A_MASK, 8'hFF);
        irq_seen = 1'b0;
        repeat (20) begin
            @(posedge clk_i); #1;
            if (irq_o) irq_seen = 1'b1;
        end
        chk("t1_irq20", 8'(irq_seen), 8'h00);
        wb_cycle(1'b0, GPIA_A_STAT, 8'h00);
        chk("t1_ack", 8'(s_ack), 8'h01);
        chk("t1_stat", s_dat, 8'h00);
        wb_cycle(1'b0, GPIA_A_POL, 8'h00);
        chk("t1_pol", s_dat, 8'hFF);
        wb_cycle(1'b0, GPIA_A_IN, 8'h00);
        chk("t1_in", s_dat, 8'hFF);
        wb_cycle(1'b1, GPIA_A_MASK, 8'h00);

        // 2: set then toggle, read back
        wb_cycle(1'b1, 3'd1, 8'h0F);
        chk("t2_ack", 8'(s_ack), 8'h01);
        chk("t2_gstb", 8'(s_gstb), 8'h01);
        chk("t2_mode", 8'(s_mode), 8'h01);
        chk("t2_d", s_d, 8'h0F);
        @(posedge clk_i); #1;
        chk("t2_ack_drop", 8'(ack_o), 8'h00);
        chk("t2_gstb_drop", 8'(gstb_o), 8'h00);
        wb_cycle(1'b0, GPIA_A_OUT, 8'h00);
        chk("t2_rd0", s_dat, 8'h0F);
        chk("t2_rd_nogstb", 8'(s_gstb), 8'h00);
        wb_cycle(1'b1, 3'd3, 8'hFF);
        chk("t2_tgl_mode", 8'(s_mode), 8'h03);
        wb_cycle(1'b0, GPIA_A_OUT, 8'h00);
        chk("t2_rd1", s_dat, 8'hF0);
        @(posedge clk_i); #1;
        chk("t2_dat_idle", dat_o, 8'h00);
        wb_cycle(1'b1, GPIA_A_IN, 8'hAA);
        chk("t2_w4_ack", 8'(s_ack), 8'h01);
        chk("t2_w4_gstb", 8'(s_gstb), 8'h00);

        // 3: back-to-back requests, clear bit 4 three times
        @(posedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 3'd2; dat_i = 8'h10;
        for (int i = 0; i < 6; i++) begin
            chk("t3_ack", 8'(ack_o), 8'(i % 2));
            chk("t3_gstb", 8'(gstb_o), 8'(i % 2));
            @(posedge clk_i); #1;
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        wb_cycle(1'b0, GPIA_A_OUT, 8'h00);
        chk("t3_rd", s_dat, 8'hE0);

        // 4: falling edge on bit 0, interrupt, clear
        wb_cycle(1'b1, GPIA_A_POL, 8'h00);
        wb_cycle(1'b1, GPIA_A_MASK, 8'h01);
        wb_cycle(1'b0, GPIA_A_STAT, 8'h00);
        chk("t4_pol_noedge", s_dat, 8'h00);
        @(posedge clk_i); #1 port_i = 8'hFE;
        @(posedge clk_i); #1 chk("t4_irq_e1", 8'(irq_o), 8'h00);
        @(posedge clk_i); #1 chk("t4_irq_e2", 8'(irq_o), 8'h00);
        @(posedge clk_i); #1 chk("t4_irq_e3", 8'(irq_o), 8'h00);
        @(posedge clk_i); #1 chk("t4_irq_e4", 8'(irq_o), 8'h01);
        wb_cycle(1'b0, GPIA_A_STAT, 8'h00);
        chk("t4_stat", s_dat, 8'h01);
        wb_cycle(1'b1, GPIA_A_STAT, 8'h01);
        chk("t4_irq_hold", 8'(irq_o), 8'h01);
        @(posedge clk_i); #1;
        chk("t4_irq_clr", 8'(irq_o), 8'h00);
        wb_cycle(1'b0, GPIA_A_STAT, 8'h00);
        chk("t4_stat_clr", s_dat, 8'h00);

        // 5: W1C collides with the edge on bit 2
        @(posedge clk_i); #1 port_i = 8'hFA;
        @(posedge clk_i);
        wb_cycle(1'b1, GPIA_A_STAT, 8'h04);
        chk("t5_ack", 8'(s_ack), 8'h01);
        wb_cycle(1'b0, GPIA_A_STAT, 8'h00);
        chk("t5_setwins", s_dat, 8'h04);
        chk("t5_irq_masked", 8'(irq_o), 8'h00);
        wb_cycle(1'b1, GPIA_A_STAT, 8'h04);
        wb_cycle(1'b0, GPIA_A_STAT, 8'h00);
        chk("t5_clr", s_dat, 8'h00);

        // 6: reset in the ack cycle of a write
        wb_cycle(1'b1, GPIA_A_POL, 8'h5A);
        wb_cycle(1'b1, GPIA_A_MASK, 8'h0F);
        wb_cycle(1'b0, GPIA_A_POL, 8'h00);
        chk("t6_pol_set", s_dat, 8'h5A);
        @(posedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 3'd1; dat_i = 8'h33;
        @(posedge clk_i); #1;
        chk("t6_ack_pre", 8'(ack_o), 8'h01);
        res_i = 1'b1;
        #1;
        chk("t6_ack_rst", 8'(ack_o), 8'h00);
        chk("t6_gstb_rst", 8'(gstb_o), 8'h00);
        chk("t6_mode_rst", 8'(mode_o), 8'h00);
        chk("t6_d_rst", d_o, 8'h00);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk_i); #1 res_i = 1'b0;
        wb_cycle(1'b0, GPIA_A_POL, 8'h00);
        chk("t6_pol", s_dat, 8'hFF);
        wb_cycle(1'b0, GPIA_A_MASK, 8'h00);
        chk("t6_mask", s_dat, 8'h00);
        wb_cycle(1'b0, GPIA_A_STAT, 8'h00);
        chk("t6_stat", s_dat, 8'h00);
        chk("t6_irq", 8'(irq_o), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
